// File: rtl/timer_pkg.sv
// Shared definitions for the timer and its monitor: FSM encoding, read map, status layout.
package timer_pkg;

  localparam int unsigned RADDR_W = 2;

  // Measurement FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Read register addresses
  localparam logic [RADDR_W-1:0] RADDR_HIGH   = 2'd0;
  localparam logic [RADDR_W-1:0] RADDR_LOW    = 2'd1;
  localparam logic [RADDR_W-1:0] RADDR_PERIOD = 2'd2;
  localparam logic [RADDR_W-1:0] RADDR_STATUS = 2'd3;

  // Status register payload, LSB first: busy, done, ovf
  typedef struct packed {
    logic ovf;
    logic done;
    logic busy;
  } status_t;

endpackage

// File: rtl/edge_detect.sv
// Single-register edge detector; edges are suppressed in the first cycle after reset
// so that a level already present at reset release is not taken as an edge.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q, d_d;
  logic armed_q, armed_d;

  // Next-state for the sampled input and the post-reset arm flag
  always_comb begin
    d_d     = d;
    armed_d = 1'b1;
  end

  // Input register and arm flag
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q     <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      d_q     <= d_d;
      armed_q <= armed_d;
    end
  end

  // Edges in the same cycle the input changes
  always_comb begin
    rise = armed_q & d & ~d_q;
    fall = armed_q & ~d & d_q;
  end

endmodule

// File: rtl/timer_monitor.sv
// Measures high width, low width and period count of an upstream PWM until the
// timer signals end-of-run; results are exposed through a 4-entry read map.
module timer_monitor
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_pwm,
  input  logic               i_timer_end,
  input  logic               i_clr,
  input  logic               i_re,
  input  logic [RADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]   o_rdata,
  output logic               o_rvalid,
  output logic               o_irq
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic pwm_rise, pwm_fall;
  logic te_rise, te_fall_unused;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] high_width_q, high_width_d;
  logic [WIDTH-1:0] low_width_q, low_width_d;
  logic [WIDTH-1:0] period_cnt_q, period_cnt_d;
  logic             ovf_q, ovf_d;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;

  logic [WIDTH-1:0] cnt_inc, period_inc;
  status_t          status_c;

  edge_detect u_pwm_edge (
    .clk  (i_clk),
    .rst  (i_rst),
    .d    (i_pwm),
    .rise (pwm_rise),
    .fall (pwm_fall)
  );

  edge_detect u_te_edge (
    .clk  (i_clk),
    .rst  (i_rst),
    .d    (i_timer_end),
    .rise (te_rise),
    .fall (te_fall_unused)
  );

  // Saturating increments of the running counter and the period counter
  always_comb begin
    cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    period_inc = (period_cnt_q == CNT_MAX) ? period_cnt_q : period_cnt_q + CNT_ONE;
  end

  // Measurement FSM: clear beats timer end, timer end beats pwm edges
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    high_width_d = high_width_q;
    low_width_d  = low_width_q;
    period_cnt_d = period_cnt_q;
    ovf_d        = ovf_q;
    irq_d        = irq_q;

    if (i_clr) begin
      state_d      = ST_IDLE;
      cnt_d        = '0;
      high_width_d = '0;
      low_width_d  = '0;
      period_cnt_d = '0;
      ovf_d        = 1'b0;
      irq_d        = 1'b0;
    end else if ((state_q != ST_DONE) && te_rise) begin
      state_d = ST_DONE;
      irq_d   = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pwm_rise) begin
            state_d = ST_HIGH;
            cnt_d   = CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (pwm_fall) begin
            high_width_d = cnt_q;
            cnt_d        = CNT_ONE;
            state_d      = ST_LOW;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) ovf_d = 1'b1;
          end
        end
        ST_LOW: begin
          if (pwm_rise) begin
            low_width_d  = cnt_q;
            period_cnt_d = period_inc;
            if (period_inc == CNT_MAX) ovf_d = 1'b1;
            cnt_d        = CNT_ONE;
            state_d      = ST_HIGH;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) ovf_d = 1'b1;
          end
        end
        ST_DONE: begin
        end
      endcase
    end
  end

  // Read mux: samples pre-update register values in the strobe cycle
  always_comb begin
    status_c      = '0;
    status_c.ovf  = ovf_q;
    status_c.done = (state_q == ST_DONE);
    status_c.busy = (state_q == ST_HIGH) || (state_q == ST_LOW);

    rdata_d  = rdata_q;
    rvalid_d = i_re;
    if (i_re) begin
      unique case (i_raddr)
        RADDR_HIGH:   rdata_d = high_width_q;
        RADDR_LOW:    rdata_d = low_width_q;
        RADDR_PERIOD: rdata_d = period_cnt_q;
        RADDR_STATUS: rdata_d = WIDTH'(status_c);
      endcase
    end
  end

  // State and result registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      high_width_q <= '0;
      low_width_q  <= '0;
      period_cnt_q <= '0;
      ovf_q        <= 1'b0;
      irq_q        <= 1'b0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      high_width_q <= high_width_d;
      low_width_q  <= low_width_d;
      period_cnt_q <= period_cnt_d;
      ovf_q        <= ovf_d;
      irq_q        <= irq_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
    end
  end

  assign o_rdata  = rdata_q;
  assign o_rvalid = rvalid_q;
  assign o_irq    = irq_q;

endmodule

// File: doc/timer_monitor.md
TIMER_MONITOR -- requirements
Module: timer_monitor

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the width of all measurement counters and the read data bus.
REQ-002 i_clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-003 i_rst  input  1  reset; synchronous and active-high.
REQ-004 i_pwm  input  1  PWM output of the upstream timer, same clock domain.
REQ-005 i_timer_end  input  1  end-of-run flag of the upstream timer, level.
REQ-006 i_clr  input  1  one-cycle pulse: clear all measurements and return to IDLE.
REQ-007 i_re  input  1  read strobe.
REQ-008 i_raddr  input  2  read register select.
REQ-009 o_rdata  output  WIDTH  read data.
REQ-010 o_rvalid  output  1  o_rdata is valid.
REQ-011 o_irq  output  1  run finished, level, held until cleared.

Function
REQ-012 i_pwm and i_timer_end SHALL each be registered once; rise = input & ~reg, fall = ~input & reg, evaluated in the same cycle the input changes.
REQ-013 FSM states SHALL be IDLE, HIGH, LOW and DONE.
REQ-014 IDLE -> HIGH on pwm rise: cnt <= 1. A pwm level already high on leaving reset SHALL NOT start a measurement.
REQ-015 HIGH: cnt SHALL increment each cycle. On pwm fall: high_width <= cnt, cnt <= 1, next state LOW.
REQ-016 LOW: cnt SHALL increment each cycle. On pwm rise: low_width <= cnt, period_cnt += 1, cnt <= 1, next state HIGH.
REQ-017 Widths SHALL be exact: a high pulse of N cycles SHALL give high_width = N.
REQ-018 cnt and period_cnt SHALL saturate at 2^WIDTH-1, never wrap. Reaching saturation SHALL set sticky flag ovf.
REQ-019 Timer-end rise in IDLE, HIGH or LOW: next state DONE and o_irq <= 1. The partial measurement in progress SHALL be discarded and all registers frozen.
REQ-020 Timer-end rise and pwm edge in the same cycle: timer-end SHALL win; no width is latched.
REQ-021 DONE SHALL ignore i_pwm and i_timer_end; it SHALL be left only by i_clr or i_rst.
REQ-022 i_clr SHALL zero cnt, high_width, low_width, period_cnt, ovf and o_irq, with next state IDLE, from any state.
REQ-023 i_clr SHALL take priority over any coincident edge.
REQ-024 Read map:
- 0 = high_width
- 1 = low_width
- 2 = period_cnt
- 3 = status {zeros, ovf, done, busy}, where busy = state is HIGH or LOW and done = state is DONE.
REQ-025 Read latency SHALL be 1 cycle: o_rvalid = i_re delayed one cycle. o_rdata SHALL be captured in the i_re cycle and held until the next read.
REQ-026 A read coinciding with a latch SHALL return the pre-update value.
REQ-027 Back-to-back reads SHALL be accepted every cycle.

Reset
REQ-028 On i_rst = 1 at a clock edge, the block SHALL enter IDLE with these outputs and registers at 0: o_rdata, o_rvalid, o_irq, cnt, high_width, low_width, period_cnt, ovf, and both input registers.
REQ-029 Reset mid-measurement SHALL discard all data. The first cycle after reset SHALL be treated as IDLE with no edge pending.
REQ-030 Reset SHALL override i_clr and i_re.

Structure
REQ-031 State encoding and the four read-address constants SHALL live in shared package timer_pkg, which the timer and its neighbours also use.
REQ-032 Edge detection SHALL be one reusable sub-module, edge_detect (inputs: clk, rst, d; outputs: rise, fall), instantiated twice.
REQ-033 All remaining logic (FSM, counters, read mux) SHALL live in timer_monitor.

Verification
REQ-034 PWM high 3 / low 5, four full periods, then read 0, 1, 2 -> 3, 5, 4. Each o_rvalid SHALL be exactly 1 cycle after its i_re.
REQ-035 i_pwm already 1 when reset is released; then fall, then a 2-cycle high pulse -> high_width = 2 and period_cnt = 0 (no rise after it yet).
REQ-036 WIDTH = 4, 20-cycle high pulse -> high_width = 15 and status ovf = 1 after the fall.
REQ-037 Timer-end rise in the same cycle as a pwm fall -> high_width unchanged, o_irq = 1 next cycle, status = done. Later pwm edges SHALL change nothing. i_clr SHALL then give o_irq = 0 and all reads = 0.
REQ-038 i_rst asserted mid-LOW after 2 periods -> all reads 0, o_irq = 0. Measurement SHALL resume correctly on the next pwm rise.
